// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock; releases sys_rst_n after stable lock.
// Optional macro PLL_LOCK_SEQ_RETRY_EN: lock timeout retries the PLL instead of entering FAULT.
module pll_lock_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int HOLD_CYCLES         = 64,
    parameter int CNT_W               = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        PLL_RST_S   = 3'd0,
        WAIT_LOCK_S = 3'd1,
        HOLD_S      = 3'd2,
        RUN_S       = 3'd3
`ifndef PLL_LOCK_SEQ_RETRY_EN
        , FAULT_S   = 3'd4
`endif
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cyc_cnt, cyc_cnt_nxt;
    logic [CNT_W-1:0] stb_cnt, stb_cnt_nxt;
    logic             lock_meta, lock_s;
    logic             loss_inc;
    logic [7:0]       loss_cnt_nxt;
    logic             pll_rst_nxt, sys_rst_n_nxt, ready_nxt;

    // Two-flop synchronizer plus state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_meta     <= 1'b0;
            lock_s        <= 1'b0;
            state         <= PLL_RST_S;
            cyc_cnt       <= '0;
            stb_cnt       <= '0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            lock_meta     <= pll_locked;
            lock_s        <= lock_meta;
            state         <= state_nxt;
            cyc_cnt       <= cyc_cnt_nxt;
            stb_cnt       <= stb_cnt_nxt;
            pll_rst       <= pll_rst_nxt;
            sys_rst_n     <= sys_rst_n_nxt;
            ready         <= ready_nxt;
            lock_loss_cnt <= loss_cnt_nxt;
        end
    end

    // Next state; stable completion is tested before timeout so HOLD wins a tie.
    always_comb begin
        state_nxt   = state;
        cyc_cnt_nxt = cyc_cnt + 1'b1;
        stb_cnt_nxt = '0;
        loss_inc    = 1'b0;
        case (state)
            PLL_RST_S: begin
                if (cyc_cnt == RST_LAST) state_nxt = WAIT_LOCK_S;
            end
            WAIT_LOCK_S: begin
                if (lock_s) stb_cnt_nxt = stb_cnt + 1'b1;
                if (lock_s && (stb_cnt == STABLE_LAST)) begin
                    state_nxt = HOLD_S;
                end else if (cyc_cnt == TIMEOUT_LAST) begin
`ifdef PLL_LOCK_SEQ_RETRY_EN
                    state_nxt = PLL_RST_S;
`else
                    state_nxt = FAULT_S;
`endif
                end
            end
            HOLD_S: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST_S;
                    loss_inc  = 1'b1;
                end else if (cyc_cnt == HOLD_LAST) begin
                    state_nxt = RUN_S;
                end
            end
            RUN_S: begin
                if (!lock_s) begin
                    state_nxt = PLL_RST_S;
                    loss_inc  = 1'b1;
                end
            end
`ifndef PLL_LOCK_SEQ_RETRY_EN
            FAULT_S: begin
                state_nxt = FAULT_S;
            end
`endif
            default: begin
                state_nxt = PLL_RST_S;
            end
        endcase
        if (state_nxt != state) cyc_cnt_nxt = '0;
        if (state_nxt != WAIT_LOCK_S) stb_cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_comb begin
        pll_rst_nxt   = (state_nxt == PLL_RST_S);
`ifndef PLL_LOCK_SEQ_RETRY_EN
        pll_rst_nxt   = pll_rst_nxt || (state_nxt == FAULT_S);
`endif
        sys_rst_n_nxt = (state_nxt == RUN_S);
        ready_nxt     = (state_nxt == RUN_S);
        loss_cnt_nxt  = lock_loss_cnt;
        if (loss_inc && (lock_loss_cnt != 8'hFF)) loss_cnt_nxt = lock_loss_cnt + 8'd1;
    end

`ifdef PLL_LOCK_SEQ_RETRY_EN
    assign fault = 1'b0;
`else
    always_ff @(posedge clk) begin
        if (!rst) fault <= 1'b0;
        else      fault <= (state_nxt == FAULT_S);
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with short test-plan parameters.
// Timeout expectations follow PLL_LOCK_SEQ_RETRY_EN when it is defined for the build.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];

    pll_lock_sequencer #(
        .PLL_RST_CYCLES(4),
        .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(40),
        .HOLD_CYCLES(4),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n),
        .ready(ready),
        .fault(fault),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Waits on negedges until the chosen output (0: pll_rst, 1: ready) reaches level.
    task automatic wait_for(input int which, input logic level, input int limit,
                            output int cycles, output bit ok);
        logic sig;
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            cycles++;
            sig = (which == 0) ? pll_rst : ready;
            if (sig === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset(input logic lock_level);
        rst        = 1'b0;
        pll_locked = lock_level;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (pll_rst !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_pll_rst: got %b expected 1", pll_rst); end
        tests_run++;
        if (sys_rst_n !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sys_rst_n: got %b expected 0", sys_rst_n); end
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        tests_run++;
        if (fault !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
        tests_run++;
        if (lock_loss_cnt !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_loss_cnt: got %0d expected 0", lock_loss_cnt); end
        rst = 1'b1;
    endtask

    task automatic test_lock_to_ready();
        int cyc, exp;
        bit ok;
        wait_for(0, 1'b0, 50, cyc, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL first_pll_rst_fall: got timeout expected fall"); return; end
        repeat (10) @(negedge clk);
        pll_locked = 1'b1;
        exp_q.push_back(14);
        wait_for(1, 1'b1, 100, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc !== exp) begin tests_failed++; $display("[TB] FAIL lock_to_ready_latency: got %0d (ok=%0d) expected %0d", cyc, ok, exp); end
        tests_run++;
        if (sys_rst_n !== 1'b1 || pll_rst !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL run_outputs: got sys_rst_n=%b pll_rst=%b expected 1/0", sys_rst_n, pll_rst);
        end
    endtask

    task automatic test_glitch();
        int cyc, exp;
        bit ok, early;
        apply_reset(1'b0);
        wait_for(0, 1'b0, 50, cyc, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL glitch_pll_rst_fall: got timeout expected fall"); return; end
        early = 1'b0;
        pll_locked = 1'b1;
        repeat (5) begin @(negedge clk); if (ready !== 1'b0) early = 1'b1; end
        pll_locked = 1'b0;
        @(negedge clk);
        if (ready !== 1'b0) early = 1'b1;
        pll_locked = 1'b1;
        exp_q.push_back(14);
        wait_for(1, 1'b1, 100, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (early) begin tests_failed++; $display("[TB] FAIL glitch_no_ready: got ready during pulse expected 0"); end
        tests_run++;
        if (!ok || cyc !== exp) begin tests_failed++; $display("[TB] FAIL glitch_latency: got %0d (ok=%0d) expected %0d", cyc, ok, exp); end
    endtask

    task automatic test_lock_loss();
        int cyc, exp, width;
        bit ok;
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b1 || sys_rst_n !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL loss_edge2: got ready=%b sys_rst_n=%b expected 1/1", ready, sys_rst_n);
        end
        @(negedge clk);
        tests_run++;
        if (sys_rst_n !== 1'b0 || ready !== 1'b0 || pll_rst !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL loss_edge3: got sys_rst_n=%b ready=%b pll_rst=%b expected 0/0/1", sys_rst_n, ready, pll_rst);
        end
        exp_q.push_back(1);
        exp = exp_q.pop_front();
        tests_run++;
        if (lock_loss_cnt !== 8'(exp)) begin tests_failed++; $display("[TB] FAIL loss_cnt_one: got %0d expected %0d", lock_loss_cnt, exp); end
        width = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pll_rst === 1'b1) width++;
            else break;
        end
        tests_run++;
        if (width !== 4) begin tests_failed++; $display("[TB] FAIL pll_rst_width: got %0d expected 4", width); end
        exp_q.push_back(12);
        wait_for(1, 1'b1, 100, cyc, ok);
        exp = exp_q.pop_front();
        tests_run++;
        if (!ok || cyc !== exp) begin tests_failed++; $display("[TB] FAIL relock_latency: got %0d (ok=%0d) expected %0d", cyc, ok, exp); end
    endtask

    task automatic test_timeout();
        int cyc, low, high;
        bit ok;
        apply_reset(1'b0);
        wait_for(0, 1'b0, 50, cyc, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL timeout_pll_rst_fall: got timeout expected fall"); return; end
        low = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pll_rst === 1'b0) low++;
            else break;
        end
        tests_run++;
        if (low !== 40) begin tests_failed++; $display("[TB] FAIL timeout_wait_len: got %0d expected 40", low); end
`ifdef PLL_LOCK_SEQ_RETRY_EN
        high = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pll_rst === 1'b1) high++;
            else break;
        end
        tests_run++;
        if (high !== 4) begin tests_failed++; $display("[TB] FAIL retry_pulse_len: got %0d expected 4", high); end
        low = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pll_rst === 1'b0) low++;
            else break;
        end
        tests_run++;
        if (low !== 40 || fault !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL retry_period: got low=%0d fault=%b expected 40/0", low, fault);
        end
`else
        high = 0;
        tests_run++;
        if (fault !== 1'b1 || pll_rst !== 1'b1 || sys_rst_n !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL fault_entry: got fault=%b pll_rst=%b sys_rst_n=%b expected 1/1/0", fault, pll_rst, sys_rst_n);
        end
        repeat (50) begin
            @(negedge clk);
            if (fault !== 1'b1 || pll_rst !== 1'b1) high++;
        end
        tests_run++;
        if (high !== 0) begin tests_failed++; $display("[TB] FAIL fault_persist: got %0d bad cycles expected 0", high); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (fault !== 1'b0 || pll_rst !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL fault_clear: got fault=%b pll_rst=%b expected 0/1", fault, pll_rst);
        end
        rst = 1'b1;
`endif
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_ready: got %b expected 0", ready); end
    endtask

    task automatic test_saturation();
        int cyc, exp;
        bit ok;
        apply_reset(1'b1);
        for (int i = 1; i <= 300; i++) begin
            wait_for(1, 1'b1, 200, cyc, ok);
            if (!ok) begin
                tests_run++; tests_failed++;
                $display("[TB] FAIL sat_ready_timeout: got no ready at loss %0d expected ready", i);
                return;
            end
            pll_locked = 1'b0;
            @(negedge clk);
            pll_locked = 1'b1;
            wait_for(1, 1'b0, 10, cyc, ok);
            if (i >= 253 || (i % 50) == 0) begin
                exp_q.push_back((i > 255) ? 255 : i);
                @(negedge clk);
                exp = exp_q.pop_front();
                tests_run++;
                if (!ok || lock_loss_cnt !== 8'(exp)) begin
                    tests_failed++; $display("[TB] FAIL sat_count_%0d: got %0d (ok=%0d) expected %0d", i, lock_loss_cnt, ok, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        int cyc, exp;
        bit ok;
        wait_for(0, 1'b0, 50, cyc, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL hold_pll_rst_fall: got timeout expected fall"); return; end
        repeat (9) @(negedge clk);
        exp_q.push_back(255);
        exp = exp_q.pop_front();
        tests_run++;
        if (ready !== 1'b0 || sys_rst_n !== 1'b0 || pll_rst !== 1'b0 || lock_loss_cnt !== 8'(exp)) begin
            tests_failed++; $display("[TB] FAIL in_hold: got ready=%b sys_rst_n=%b pll_rst=%b cnt=%0d expected 0/0/0/%0d",
                                     ready, sys_rst_n, pll_rst, lock_loss_cnt, exp);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (pll_rst !== 1'b1 || sys_rst_n !== 1'b0 || ready !== 1'b0 || fault !== 1'b0 || lock_loss_cnt !== 8'd0) begin
            tests_failed++; $display("[TB] FAIL hold_reset: got pll_rst=%b sys_rst_n=%b ready=%b fault=%b cnt=%0d expected 1/0/0/0/0",
                                     pll_rst, sys_rst_n, ready, fault, lock_loss_cnt);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (ready !== 1'b0 || pll_rst !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL hold_reset_stays: got ready=%b pll_rst=%b expected 0/1", ready, pll_rst);
        end
        rst = 1'b1;
    endtask

    initial begin
        rst        = 1'b0;
        pll_locked = 1'b0;
        test_reset();
        test_lock_to_ready();
        test_glitch();
        test_lock_loss();
        test_timeout();
        test_saturation();
        test_reset_mid_hold();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
